bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 101 ++++++++++
 tb/tb_bit_serializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with optional gap-free frame repeat.
// The serial bit, busy, done and bit_cnt are all driven straight from flops.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             rpt,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [3:0]       cnt_n;
  logic             x_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      hold    <= '0;
      bit_cnt <= '0;
      x       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      hold    <= hold_n;
      bit_cnt <= cnt_n;
      x       <= x_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Output flops are loaded with the value they must show after the edge,
  // so x is the next MSB of the shift register, not the current one.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    hold_n  = hold;
    cnt_n   = bit_cnt;
    x_n     = x;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      SHIFT: begin
        busy_n = 1'b1;
        if (en) begin
          if (bit_cnt == LAST) begin
            done_n = 1'b1;
            cnt_n  = '0;
            if (rpt) begin
              sreg_n = hold;
              x_n    = hold[WIDTH-1];
            end else begin
              state_n = DONE;
              busy_n  = 1'b0;
              x_n     = 1'b0;
            end
          end else begin
            sreg_n = {sreg[WIDTH-2:0], 1'b0};
            cnt_n  = bit_cnt + 4'd1;
            x_n    = sreg[WIDTH-2];
          end
        end
      end
      default: begin
        // IDLE and DONE behave alike: DONE only exists to mark the gap cycle.
        state_n = IDLE;
        x_n     = 1'b0;
        busy_n  = 1'b0;
        cnt_n   = '0;
        if (load) begin
          sreg_n  = din;
          hold_n  = din;
          state_n = SHIFT;
          x_n     = din[WIDTH-1];
          busy_n  = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed vector table, corner-case
// sequences and a randomized run against a frame-level reference model.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, load, en, rpt;
  logic [W-1:0] din;
  logic         x, busy, done;
  logic [3:0]   bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din), .en(en), .rpt(rpt),
    .x(x), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a captured word plus the index of the bit on x.
  bit         m_active = 0;
  logic [W-1:0] m_frame = '0;
  int         m_idx = 0;
  bit         m_done = 0;
  bit         prev_done = 0;

  function automatic void model_step(logic r, logic l, logic [W-1:0] d, logic e, logic p);
    m_done = 0;
    if (r) begin
      m_active = 0;
      m_idx    = 0;
    end else if (!m_active) begin
      if (l) begin
        m_frame  = d;
        m_idx    = 0;
        m_active = 1;
      end
    end else if (e) begin
      if (m_idx == W - 1) begin
        m_done = 1;
        m_idx  = 0;
        if (!p) m_active = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(logic r, logic l, logic [W-1:0] d, logic e, logic p);
    logic ex;
    reset = r; load = l; din = d; en = e; rpt = p;
    @(posedge clk);
    model_step(r, l, d, e, p);
    #1;
    ex = m_active ? m_frame[W-1-m_idx] : 1'b0;
    check("model_x", 16'(x), 16'(ex));
    check("model_busy", 16'(busy), 16'(m_active));
    check("model_done", 16'(done), 16'(m_done));
    check("model_bit_cnt", 16'(bit_cnt), 16'(m_idx));
    check("done_consecutive", 16'(prev_done & done), 16'd0);
    prev_done = done;
  endtask

  typedef struct {
    logic r, l; logic [W-1:0] d; logic e, p;
    logic ex, eb, ed; logic [3:0] ec;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r, logic l, logic [W-1:0] d, logic e, logic p,
                              logic ex, logic eb, logic ed, logic [3:0] ec);
    vec_t v;
    v.r = r; v.l = l; v.d = d; v.e = e; v.p = p;
    v.ex = ex; v.eb = eb; v.ed = ed; v.ec = ec;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, en_hi, n;
    reset = 1; load = 0; din = '0; en = 0; rpt = 0;

    // Directed table: reset, 8'hA5 frame with en held high, back-to-back reload.
    add(1, 0, 8'h00, 1, 0,  0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0,  0, 0, 0, 0);
    add(0, 1, 8'hA5, 1, 0,  1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,  0, 1, 0, 1);
    add(0, 1, 8'hFF, 1, 0,  1, 1, 0, 2);
    add(0, 0, 8'h00, 1, 0,  0, 1, 0, 3);
    add(0, 0, 8'h00, 1, 0,  0, 1, 0, 4);
    add(0, 0, 8'h00, 1, 0,  1, 1, 0, 5);
    add(0, 0, 8'h00, 1, 0,  0, 1, 0, 6);
    add(0, 0, 8'h00, 1, 0,  1, 1, 0, 7);
    add(0, 1, 8'h81, 1, 0,  0, 0, 1, 0);
    add(0, 1, 8'h81, 0, 0,  1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0,  1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,  0, 1, 0, 1);
    add(1, 1, 8'hFF, 1, 1,  0, 0, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].d, tbl[i].e, tbl[i].p);
      check($sformatf("tbl%0d_x", i), 16'(x), 16'(tbl[i].ex));
      check($sformatf("tbl%0d_busy", i), 16'(busy), 16'(tbl[i].eb));
      check($sformatf("tbl%0d_done", i), 16'(done), 16'(tbl[i].ed));
      check($sformatf("tbl%0d_bit_cnt", i), 16'(bit_cnt), 16'(tbl[i].ec));
    end

    // Enable high with no load: stays idle.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, W'($urandom), 1, 0);
      check("idle_x", 16'(x), 16'd0);
      check("idle_busy", 16'(busy), 16'd0);
    end

    // Toggled enable: every bit held for two cycles, 8 en-high cycles to done.
    step(0, 1, 8'hA5, 0, 0);
    en_hi = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, W'($urandom), logic'(i % 2), 0);
      if (i % 2 == 1) en_hi++;
      if (done) break;
    end
    check("toggle_en_count", 16'(en_hi), 16'd8);

    // Repeat mode: continuous F0 frames, then release rpt and finish the frame.
    step(0, 1, 8'hF0, 1, 1);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 0, W'($urandom), 1, 1);
      if (done) cnt++;
      check("rpt_busy", 16'(busy), 16'd1);
    end
    check("rpt_done_count", 16'(cnt), 16'd3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8'h00, 1, 0);
      n++;
      if (done) break;
    end
    check("rpt_stop_len", 16'(n), 16'd8);
    step(0, 0, 8'h00, 1, 0);
    check("rpt_stop_idle", 16'(busy), 16'd0);

    // Loads during a frame are ignored.
    step(0, 1, 8'hFF, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 8'h00, 1, 0);
      check("ignore_load_x", 16'(x), 16'd1);
    end
    step(0, 1, 8'h00, 1, 0);
    check("ignore_load_done", 16'(done), 16'd1);

    // Reset mid-frame aborts without done; a new load starts cleanly.
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'hA5, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
    check("abort_cnt_before", 16'(bit_cnt), 16'd3);
    step(1, 1, 8'hFF, 1, 1);
    check("abort_x", 16'(x), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_cnt", 16'(bit_cnt), 16'd0);
    step(0, 1, 8'h3C, 1, 0);
    check("restart_x", 16'(x), 16'd0);
    check("restart_busy", 16'(busy), 16'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0);
    check("restart_done", 16'(done), 16'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 3) == 0),
           W'($urandom), logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
